fifo_stream_reader: RTL and testbench

Read-side master for the team's 32-deep x 32-bit synchronous FIFO. It drives the FIFO's `re` and consumes `rd_data` and `fifo_empty`, absorbing the FIFO RAM's one-cycle registered read latency. It presents the drained words downstream as a valid/ready stream with a `last` marker every BURST_LEN words. It sits between the FIFO and any consumer that applies backpressure. Throughput is one word per cycle when `m_ready` is held high.

---
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO with one-cycle read latency
// and presents the words as a valid/ready stream with a periodic last marker.
//
// Handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
// m_valid is raised without waiting for m_ready, and once raised, m_valid,
// m_data and m_last hold until that transfer happens (reset excepted).
module fifo_stream_reader #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_re,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  burst_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  // Two-entry output buffer: head drives m_data, tail is the spare slot that
  // absorbs the word already in flight when the consumer stalls.
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pop;
  logic              re;
  logic [2:0]        credit;

  // Read credit: words the buffer will hold after this edge, before any new issue.
  always_comb begin
    pop    = (occ_q != 2'd0) && m_ready;
    credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    re     = !rst && en && !fifo_empty && (credit <= 3'd1);
  end

  // Next-state for the buffer, in-flight flag and burst counter.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = re;
    cnt_d      = cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_rd_data;
        else               tail_d = fifo_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Pop and capture together: occupancy unchanged, queue shifts by one.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = fifo_rd_data;
        end else begin
          head_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
    if (pop) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    fifo_re   = re;
    m_valid   = (occ_q != 2'd0);
    m_data    = head_q;
    m_last    = (occ_q != 2'd0) && (cnt_q == LAST_CNT);
    burst_cnt = cnt_q;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader with a
// behavioural FIFO, an expected-word queue and per-beat stream checks.
module tb_fifo_stream_reader;

  localparam int BURST_LEN = 8;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic        fifo_re;
  logic [31:0] fifo_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [7:0]  burst_cnt;

  // FIFO model controls
  logic        fifo_rst;
  logic        wr_en;
  logic [31:0] wr_data;

  // scoreboard state
  logic [31:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;
  int          beat_cnt;
  int          beats;
  int          issues;
  logic        stall;
  logic [31:0] stall_data;
  logic        stall_last;

  typedef struct {
    logic        en;
    logic        m_ready;
    logic        exp_re;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[19];

  fifo_stream_reader #(.DATA_W(32), .BURST_LEN(BURST_LEN), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_re      (fifo_re),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .burst_cnt    (burst_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous FIFO with registered read data
  logic [31:0] fmem [256];
  logic [7:0]  wptr;
  logic [7:0]  rptr;
  logic [8:0]  fcnt;

  assign fifo_empty = (fcnt == 9'd0);

  always @(posedge clk) begin
    if (fifo_rst) begin
      wptr <= 8'd0;
      rptr <= 8'd0;
      fcnt <= 9'd0;
    end else begin
      if (wr_en) begin
        fmem[wptr] <= wr_data;
        wptr       <= wptr + 8'd1;
      end
      if (fifo_re && !fifo_empty) begin
        fifo_rd_data <= fmem[rptr];
        rptr         <= rptr + 8'd1;
      end
      fcnt <= fcnt + 9'(wr_en) - 9'(fifo_re && !fifo_empty);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // per-cycle stream checks, called after inputs settle
  task automatic monitor();
    logic [31:0] exp;
    if (fifo_empty) chk("re_when_empty", {31'd0, fifo_re}, 32'd0);
    if (stall && !rst) begin
      chk("stall_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_data", m_data, stall_data);
      chk("stall_last", {31'd0, m_last}, {31'd0, stall_last});
    end
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_data);
      end else begin
        exp = exp_q.pop_front();
        chk("beat_data", m_data, exp);
        chk("beat_last", {31'd0, m_last}, {31'd0, (beat_cnt == BURST_LEN - 1)});
        chk("beat_cnt", {24'd0, burst_cnt}, 32'(beat_cnt));
        beat_cnt = (beat_cnt == BURST_LEN - 1) ? 0 : beat_cnt + 1;
      end
      beats++;
    end
    if (!rst && fifo_re && !fifo_empty) issues++;
    stall      = !rst && m_valid && !m_ready;
    stall_data = m_data;
    stall_last = m_last;
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_all();
    rst      = 1'b1;
    fifo_rst = 1'b1;
    m_ready  = 1'b0;
    wr_en    = 1'b0;
    exp_q.delete();
    beat_cnt = 0;
    tick();
    rst      = 1'b0;
    fifo_rst = 1'b0;
  endtask

  initial begin
    int b0;
    int n;
    int sent;

    // latency/stream table: issues on cycles 0..15, beats on cycles 2..17
    for (int k = 0; k < 19; k++) begin
      vecs[k].en        = 1'b1;
      vecs[k].m_ready   = 1'b1;
      vecs[k].exp_re    = (k <= 15);
      vecs[k].exp_valid = (k >= 2) && (k <= 17);
      vecs[k].exp_data  = 32'hA0 + 32'(k - 2);
      vecs[k].exp_last  = (k == 9) || (k == 17);
      vecs[k].exp_cnt   = (k < 2) ? 8'd0 : 8'((k - 2) % BURST_LEN);
    end

    pass_cnt  = 0;
    total_cnt = 0;
    beat_cnt  = 0;
    beats     = 0;
    issues    = 0;
    stall     = 1'b0;
    stall_data = 32'd0;
    stall_last = 1'b0;
    rst       = 1'b1;
    fifo_rst  = 1'b1;
    en        = 1'b0;
    m_ready   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 32'd0;
    @(negedge clk);
    tick();
    tick();

    // reset holds the stream quiet even with a non-empty FIFO
    fifo_rst = 1'b0;
    en       = 1'b1;
    m_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h55 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_re", {31'd0, fifo_re}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      chk("rst_cnt", {24'd0, burst_cnt}, 32'd0);
      chk("rst_data", m_data, 32'd0);
      tick();
    end
    en = 1'b0;
    reset_all();

    // latency and full-rate stream
    for (int i = 0; i < 16; i++) write_word(32'hA0 + 32'(i));
    for (int k = 0; k < 19; k++) begin
      en      = vecs[k].en;
      m_ready = vecs[k].m_ready;
      #1;
      chk($sformatf("tbl%0d_re", k), {31'd0, fifo_re}, {31'd0, vecs[k].exp_re});
      chk($sformatf("tbl%0d_valid", k), {31'd0, m_valid}, {31'd0, vecs[k].exp_valid});
      chk($sformatf("tbl%0d_cnt", k), {24'd0, burst_cnt}, {24'd0, vecs[k].exp_cnt});
      if (vecs[k].exp_valid) begin
        chk($sformatf("tbl%0d_data", k), m_data, vecs[k].exp_data);
        chk($sformatf("tbl%0d_last", k), {31'd0, m_last}, {31'd0, vecs[k].exp_last});
      end
      monitor();
      @(negedge clk);
    end
    chk("stream_all_seen", 32'(exp_q.size()), 32'd0);

    // backpressure: two issues fill the buffer, then the reader waits
    en      = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_word(32'hB0 + 32'(i));
    issues = 0;
    en     = 1'b1;
    repeat (6) tick();
    #1;
    chk("bp_issues", 32'(issues), 32'd2);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_head", m_data, 32'hB0);
    chk("bp_re_held", {31'd0, fifo_re}, 32'd0);
    m_ready = 1'b1;
    b0 = beats;
    repeat (10) tick();
    chk("bp_no_gap", 32'(beats - b0), 32'd10);
    chk("bp_all_seen", 32'(exp_q.size()), 32'd0);

    // random backpressure with interleaved writes
    sent = 0;
    n    = 0;
    while ((sent < 200 || exp_q.size() != 0) && n < 4000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 200 && $urandom_range(0, 3) != 0) begin
        wr_en   = 1'b1;
        wr_data = $urandom;
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      n++;
    end
    wr_en = 1'b0;
    chk("rand_sent", 32'(sent), 32'd200);
    chk("rand_all_seen", 32'(exp_q.size()), 32'd0);

    // empty FIFO and enable gaps mid-burst
    reset_all();
    en      = 1'b1;
    m_ready = 1'b1;
    b0      = beats;
    for (int i = 0; i < 5; i++) write_word(32'hC0 + 32'(i));
    repeat (4) tick();
    #1;
    chk("gap_valid_low", {31'd0, m_valid}, 32'd0);
    chk("gap_cnt_held", {24'd0, burst_cnt}, 32'd5);
    en = 1'b0;
    write_word(32'hC5);
    wr_en   = 1'b1;
    wr_data = 32'hC6;
    exp_q.push_back(32'hC6);
    #1;
    chk("en_low_no_re", {31'd0, fifo_re}, 32'd0);
    tick();
    wr_en = 1'b0;
    en    = 1'b1;
    write_word(32'hC7);
    drain(20);
    #1;
    chk("gap_beats", 32'(beats - b0), 32'd8);
    chk("gap_cnt_wrap", {24'd0, burst_cnt}, 32'd0);

    // reset after three accepted words of a burst
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(32'hE0 + 32'(i));
    m_ready = 1'b1;
    b0 = beats;
    n  = 0;
    while (beats - b0 < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_three_beats", 32'(beats - b0), 32'd3);
    rst      = 1'b1;
    fifo_rst = 1'b1;
    m_ready  = 1'b0;
    exp_q.delete();
    beat_cnt = 0;
    #1;
    chk("mid_rst_re", {31'd0, fifo_re}, 32'd0);
    tick();
    rst      = 1'b0;
    fifo_rst = 1'b0;
    #1;
    chk("mid_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_cnt", {24'd0, burst_cnt}, 32'd0);
    chk("mid_data", m_data, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(32'hF0 + 32'(i));
    drain(20);
    #1;
    chk("mid_fresh_cnt", {24'd0, burst_cnt}, 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
